// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures src_clk cycles between rising edges of tick_in, with averaging and loss-of-signal timeout
module period_meter #(
    parameter int unsigned TIMEOUT  = 1_000_000,
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic        src_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        tick_in,
    output logic [31:0] period,
    output logic        period_valid,
    output logic [31:0] avg_period,
    output logic        avg_valid,
    output logic        timeout
);

    localparam int AW = 32 + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] N_FULL = NW'(2 ** AVG_LOG2);
    localparam logic [31:0]   TO_CNT = 32'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOST} state_t;

    state_t          state, state_nx;
    logic            s1, s2, s3;
    logic            rise;
    logic [31:0]     cnt, cnt_nx;
    logic [AW-1:0]   acc, acc_nx, acc_sum;
    logic [NW-1:0]   acc_n, acc_n_nx, n_inc;
    logic [31:0]     period_nx, avg_period_nx;
    logic            period_valid_nx, avg_valid_nx, timeout_nx;

    assign rise    = s2 & ~s3;
    assign acc_sum = acc + AW'(cnt);
    assign n_inc   = acc_n + NW'(1);

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        acc_nx          = acc;
        acc_n_nx        = acc_n;
        period_nx       = period;
        avg_period_nx   = avg_period;
        period_valid_nx = 1'b0;
        avg_valid_nx    = 1'b0;
        timeout_nx      = timeout;
        if (!en) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            acc_nx     = '0;
            acc_n_nx   = '0;
            timeout_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx   = '0;
                    acc_nx   = '0;
                    acc_n_nx = '0;
                    state_nx = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_nx   = 32'd1;
                        state_nx = MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the timeout cycle still counts as a valid period
                    if (rise) begin
                        cnt_nx          = 32'd1;
                        period_nx       = cnt;
                        period_valid_nx = 1'b1;
                        if (n_inc == N_FULL) begin
                            avg_period_nx = acc_sum[AVG_LOG2 +: 32];
                            avg_valid_nx  = 1'b1;
                            acc_nx        = '0;
                            acc_n_nx      = '0;
                        end else begin
                            acc_nx   = acc_sum;
                            acc_n_nx = n_inc;
                        end
                    end else if (cnt == TO_CNT) begin
                        timeout_nx = 1'b1;
                        acc_nx     = '0;
                        acc_n_nx   = '0;
                        state_nx   = LOST;
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                LOST: begin
                    if (rise) begin
                        cnt_nx     = 32'd1;
                        timeout_nx = 1'b0;
                        state_nx   = MEASURE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            acc_n        <= '0;
            period       <= '0;
            avg_period   <= '0;
            period_valid <= 1'b0;
            avg_valid    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nx;
            s1           <= tick_in;
            s2           <= s1;
            s3           <= s2;
            cnt          <= cnt_nx;
            acc          <= acc_nx;
            acc_n        <= acc_n_nx;
            period       <= period_nx;
            avg_period   <= avg_period_nx;
            period_valid <= period_valid_nx;
            avg_valid    <= avg_valid_nx;
            timeout      <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter (TIMEOUT=500, AVG_LOG2=2)
module tb_period_meter;

    logic        src_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic        tick_in = 1'b0;
    logic [31:0] period;
    logic        period_valid;
    logic [31:0] avg_period;
    logic        avg_valid;
    logic        timeout;

    period_meter #(.TIMEOUT(500), .AVG_LOG2(2)) dut (
        .src_clk      (src_clk),
        .rst_n        (rst_n),
        .en           (en),
        .tick_in      (tick_in),
        .period       (period),
        .period_valid (period_valid),
        .avg_period   (avg_period),
        .avg_valid    (avg_valid),
        .timeout      (timeout)
    );

    always #10 src_clk = ~src_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pv_cnt = 0, av_cnt = 0, to_rises = 0, pv_wide = 0;
    int last_period = 0, last_avg = 0, last_pv_cyc = 0, to_rise_cyc = 0;
    int sq_sum = 0, sq_n = 0, sq_bad = 0;
    bit sq_on = 0, prev_to = 0, prev_pv = 0;
    int nx, pv0, av0, to0, pv1;

    always @(posedge src_clk) cyc <= cyc + 1;

    // Strobe/level observer sampled away from the active edge
    always @(negedge src_clk) begin
        if (period_valid === 1'b1) begin
            pv_cnt++;
            last_period = period;
            last_pv_cyc = cyc;
            if (sq_on && sq_n < 64) begin
                sq_sum += period;
                sq_n++;
                if (period != 18 && period != 19) sq_bad++;
            end
        end
        if (avg_valid === 1'b1) begin
            av_cnt++;
            last_avg = avg_period;
        end
        if (timeout === 1'b1 && !prev_to) begin
            to_rises++;
            to_rise_cyc = cyc;
        end
        if (period_valid === 1'b1 && prev_pv) pv_wide++;
        prev_to = (timeout === 1'b1);
        prev_pv = (period_valid === 1'b1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge src_clk);
            #1;
        end
    endtask

    task automatic tick_at(input int t);
        while (cyc < t) begin
            @(posedge src_clk);
            #1;
        end
        tick_in = 1'b1;
        @(posedge src_clk);
        #1;
        tick_in = 1'b0;
    endtask

    initial begin
        int av_p[5];
        av_p = '{10, 11, 12, 14, 50};

        // Reset state
        idle(3);
        chk("rst_period", period, 0);
        chk("rst_avg", avg_period, 0);
        chk("rst_pv", period_valid, 0);
        chk("rst_av", avg_valid, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        idle(2);
        en = 1'b1;
        idle(2);

        // Steady stream: 20 pulses, 100 cycles apart
        nx = cyc + 5;
        tick_at(nx);
        for (int i = 1; i < 20; i++) begin
            nx += 100;
            tick_at(nx);
        end
        idle(10);
        chk("steady_pv_count", pv_cnt, 19);
        chk("steady_period", last_period, 100);
        chk("steady_av_count", av_cnt, 4);
        chk("steady_avg", last_avg, 100);
        chk("steady_timeout_rises", to_rises, 0);
        chk("pv_one_cycle", pv_wide, 0);

        // Enable dropped: outputs hold, timeout low
        en = 1'b0;
        idle(10);
        chk("en_off_period", period, 100);
        chk("en_off_avg", avg_period, 100);
        chk("en_off_timeout", timeout, 0);
        en = 1'b1;
        idle(3);

        // Averaging: 10,11,12,14 -> 47>>2 = 11; then 50 leaves avg alone
        pv0 = pv_cnt;
        av0 = av_cnt;
        nx = cyc + 5;
        tick_at(nx);
        for (int i = 0; i < 5; i++) begin
            nx += av_p[i];
            tick_at(nx);
        end
        idle(10);
        chk("avg_pv_count", pv_cnt - pv0, 5);
        chk("avg_av_count", av_cnt - av0, 1);
        chk("avg_value", last_avg, 11);
        chk("avg_last_period", last_period, 50);

        // Timeout 500 cycles after the last detected rise
        idle(600);
        chk("to_level", timeout, 1);
        chk("to_rises", to_rises, 1);
        chk("to_latency", to_rise_cyc - last_pv_cyc, 500);
        pv0 = pv_cnt;
        nx = cyc + 5;
        tick_at(nx);
        idle(10);
        chk("to_recover_level", timeout, 0);
        chk("to_recover_no_strobe", pv_cnt - pv0, 0);
        nx += 100;
        tick_at(nx);
        idle(10);
        chk("to_after_pv", pv_cnt - pv0, 1);
        chk("to_after_period", last_period, 100);

        // Boundary: period 500 reported, 501 times out
        to0 = to_rises;
        nx += 500;
        tick_at(nx);
        idle(10);
        chk("b500_period", last_period, 500);
        chk("b500_pv", pv_cnt - pv0, 2);
        chk("b500_no_timeout", to_rises - to0, 0);
        nx += 501;
        tick_at(nx);
        idle(10);
        chk("b501_timeout", to_rises - to0, 1);
        chk("b501_no_strobe", pv_cnt - pv0, 2);
        chk("b501_level", timeout, 0);

        // Enable dropped mid-period, first edge afterwards discarded
        nx += 100;
        tick_at(nx);
        idle(40);
        en = 1'b0;
        idle(10);
        chk("mid_en_period", period, 100);
        chk("mid_en_pv", period_valid, 0);
        en = 1'b1;
        idle(2);
        pv1 = pv_cnt;
        nx = cyc + 30;
        tick_at(nx);
        idle(10);
        chk("mid_en_discard", pv_cnt - pv1, 0);
        nx += 77;
        tick_at(nx);
        idle(10);
        chk("mid_en_period77", last_period, 77);

        // Asynchronous reset between edges
        @(posedge src_clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_period", period, 0);
        chk("arst_avg", avg_period, 0);
        chk("arst_timeout", timeout, 0);
        chk("arst_pv", period_valid, 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // 18.3-cycle square wave (366 time units) at a fractional phase
        sq_on = 1;
        #7;
        repeat (70) begin
            tick_in = 1'b1;
            #183;
            tick_in = 1'b0;
            #183;
        end
        idle(10);
        sq_on = 0;
        chk("sq_count", sq_n, 64);
        chk("sq_range", sq_bad, 0);
        chk("sq_sum_in_window", (sq_sum >= 1170 && sq_sum <= 1172), 1);
        chk("pv_one_cycle_end", pv_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
